// File: rtl/regpair_sequencer_pkg.sv
// ============================================================================
// regpair_sequencer_pkg
// Shared encodings and index helpers for the register-pair sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package regpair_sequencer_pkg;

  localparam int PAIR_W = 2;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    OP_LD16  = 2'd0,
    OP_INC16 = 2'd1,
    OP_DEC16 = 2'd2,
    OP_ADDS8 = 2'd3
  } op_e;

  localparam logic [PAIR_W-1:0] PAIR_BC = 2'd0;
  localparam logic [PAIR_W-1:0] PAIR_DE = 2'd1;
  localparam logic [PAIR_W-1:0] PAIR_HL = 2'd2;
  localparam logic [PAIR_W-1:0] PAIR_SP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WR_LO = 2'd2,
    ST_WR_HI = 2'd3
  } state_e;

  // High byte of pair p lives at 2p, low byte at 2p+1.
  function automatic logic [REG_W-1:0] hi_idx(input logic [PAIR_W-1:0] pair);
    return {pair, 1'b0};
  endfunction

  function automatic logic [REG_W-1:0] lo_idx(input logic [PAIR_W-1:0] pair);
    return {pair, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/regpair_sequencer_if.sv
// ============================================================================
// regpair_sequencer_if
// Command port (decoder side) and byte-wide bank port of the sequencer.
// Optional flag outputs present when REGPAIR_FLAGS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regpair_sequencer_if;
  import regpair_sequencer_pkg::*;

  logic                cmdValid;
  logic                cmdReady;
  logic [1:0]          cmdOp;
  logic [PAIR_W-1:0]   cmdPair;
  logic [15:0]         cmdData;
  logic [15:0]         bankData16;
  logic [REG_W-1:0]    bankRegNum;
  logic [7:0]          bankDataOut;
  logic                bankWriteEnable;
  logic                done;
  logic                busy;
`ifdef REGPAIR_FLAGS_EN
  logic                flagH;
  logic                flagC;
  logic                flagValid;
`endif

  modport master (
    input  cmdValid, cmdOp, cmdPair, cmdData, bankData16,
`ifdef REGPAIR_FLAGS_EN
    output flagH, flagC, flagValid,
`endif
    output cmdReady, bankRegNum, bankDataOut, bankWriteEnable, done, busy
  );

  modport slave (
    output cmdValid, cmdOp, cmdPair, cmdData, bankData16,
`ifdef REGPAIR_FLAGS_EN
    input  flagH, flagC, flagValid,
`endif
    input  cmdReady, bankRegNum, bankDataOut, bankWriteEnable, done, busy
  );

endinterface

`default_nettype wire

// File: rtl/regpair_sequencer_alu.sv
// ============================================================================
// regpair_alu
// Combinational 16-bit pair update; half/full carries under REGPAIR_FLAGS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regpair_alu
  import regpair_sequencer_pkg::*;
(
  input  op_e         op,
  input  logic [15:0] operand,
  input  logic [7:0]  offset,
`ifdef REGPAIR_FLAGS_EN
  output logic        hcarry,
  output logic        ccarry,
`endif
  output logic [15:0] result
);

  always_comb begin
    result = operand;
    unique case (op)
      OP_INC16: result = operand + 16'd1;
      OP_DEC16: result = operand - 16'd1;
      OP_ADDS8: result = operand + {{8{offset[7]}}, offset};
      default:  result = operand;
    endcase
  end

`ifdef REGPAIR_FLAGS_EN
  logic [4:0] w_sum_nib;
  logic [8:0] w_sum_byte;

  // Flags come from an unsigned low-byte add regardless of offset sign.
  always_comb begin
    w_sum_nib  = {1'b0, operand[3:0]} + {1'b0, offset[3:0]};
    w_sum_byte = {1'b0, operand[7:0]} + {1'b0, offset};
    hcarry     = w_sum_nib[4];
    ccarry     = w_sum_byte[8];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/regpair_sequencer.sv
// ============================================================================
// regpair_sequencer
// Turns one 16-bit pair command into byte-wise bank reads/writes.
// Optional macro: REGPAIR_FLAGS_EN (adds flagH/flagC/flagValid).
// Revision: 1.0
// ============================================================================
`default_nettype none

module regpair_sequencer
  import regpair_sequencer_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           reset,
  regpair_sequencer_if.master bus
);

  state_e            r_state;
  op_e               r_op;
  logic [PAIR_W-1:0] r_pair;
  logic [7:0]        r_offset;
  logic [15:0]       r_result;
  logic [15:0]       w_alu_result;
  op_e               w_cmd_op;

  assign w_cmd_op = op_e'(bus.cmdOp);

`ifdef REGPAIR_FLAGS_EN
  logic w_hcarry;
  logic w_ccarry;
  logic r_h_pend;
  logic r_c_pend;
`endif

  regpair_alu u_alu (
    .op      (r_op),
    .operand (bus.bankData16),
    .offset  (r_offset),
`ifdef REGPAIR_FLAGS_EN
    .hcarry  (w_hcarry),
    .ccarry  (w_ccarry),
`endif
    .result  (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_op                <= OP_LD16;
      r_pair              <= '0;
      r_offset            <= '0;
      r_result            <= '0;
      bus.cmdReady        <= 1'b1;
      bus.busy            <= 1'b0;
      bus.bankWriteEnable <= 1'b0;
      bus.bankRegNum      <= '0;
      bus.bankDataOut     <= '0;
      bus.done            <= 1'b0;
`ifdef REGPAIR_FLAGS_EN
      r_h_pend            <= 1'b0;
      r_c_pend            <= 1'b0;
      bus.flagH           <= 1'b0;
      bus.flagC           <= 1'b0;
      bus.flagValid       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
`ifdef REGPAIR_FLAGS_EN
      bus.flagValid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.cmdValid && bus.cmdReady) begin
            r_op         <= w_cmd_op;
            r_pair       <= bus.cmdPair;
            r_offset     <= bus.cmdData[7:0];
            bus.cmdReady <= 1'b0;
            bus.busy     <= 1'b1;
            // LD16 needs no read, so its low byte goes out on the very next cycle.
            if (w_cmd_op == OP_LD16) begin
              r_result            <= bus.cmdData;
              r_state             <= ST_WR_LO;
              bus.bankRegNum      <= lo_idx(bus.cmdPair);
              bus.bankDataOut     <= bus.cmdData[7:0];
              bus.bankWriteEnable <= 1'b1;
            end else begin
              r_state             <= ST_READ;
              bus.bankRegNum      <= hi_idx(bus.cmdPair);
              bus.bankDataOut     <= '0;
              bus.bankWriteEnable <= 1'b0;
            end
          end
        end

        ST_READ: begin
          r_result            <= w_alu_result;
          r_state             <= ST_WR_LO;
          bus.bankRegNum      <= lo_idx(r_pair);
          bus.bankDataOut     <= w_alu_result[7:0];
          bus.bankWriteEnable <= 1'b1;
`ifdef REGPAIR_FLAGS_EN
          r_h_pend            <= w_hcarry;
          r_c_pend            <= w_ccarry;
`endif
        end

        ST_WR_LO: begin
          r_state             <= ST_WR_HI;
          bus.bankRegNum      <= hi_idx(r_pair);
          bus.bankDataOut     <= r_result[15:8];
          bus.bankWriteEnable <= 1'b1;
          bus.done            <= 1'b1;
`ifdef REGPAIR_FLAGS_EN
          if (r_op == OP_ADDS8) begin
            bus.flagH     <= r_h_pend;
            bus.flagC     <= r_c_pend;
            bus.flagValid <= 1'b1;
          end
`endif
        end

        ST_WR_HI: begin
          r_state             <= ST_IDLE;
          bus.bankRegNum      <= '0;
          bus.bankDataOut     <= '0;
          bus.bankWriteEnable <= 1'b0;
          bus.busy            <= 1'b0;
          bus.cmdReady        <= 1'b1;
        end

        default: begin
          r_state             <= ST_IDLE;
          bus.bankWriteEnable <= 1'b0;
          bus.busy            <= 1'b0;
          bus.cmdReady        <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
